// File: rtl/edge_pkg.sv
// Shared constants and pixel types for the edge-detect pipeline.
// Imported by the grayscale feeder and the Sobel stage.
package edge_pkg;

    localparam int unsigned IMG_WIDTH    = 720;
    localparam int unsigned IMG_HEIGHT   = 540;
    localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CHAN_W       = 8;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned SUM_W        = 10;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef logic [PIX_W-1:0] pix_t;

    // Unsigned channel sum; 3*255 = 765 fits in SUM_W bits.
    function automatic logic [SUM_W-1:0] rgb_sum(input rgb_t p);
        return SUM_W'(p.r) + SUM_W'(p.g) + SUM_W'(p.b);
    endfunction

endpackage

// File: rtl/div3_u10.sv
// Combinational floor(x/3) for x in 0..765, via reciprocal multiply (x*683)>>11.
module div3_u10
    import edge_pkg::*;
(
    input  logic [SUM_W-1:0] dividend,
    output logic [PIX_W-1:0] quotient
);

    localparam int unsigned PROD_W = 20;
    localparam int unsigned SHIFT  = 11;
    localparam int unsigned RECIP  = 683;

    logic [PROD_W-1:0] prod;

    // 683/2048 overshoots 1/3 by 1/6144, small enough to stay exact below 2046.
    always_comb begin
        prod     = PROD_W'(dividend) * PROD_W'(RECIP);
        quotient = PIX_W'(prod >> SHIFT);
    end

endmodule

// File: rtl/grayscale_feeder.sv
// RGB FIFO -> luminance -> gray FIFO, two-stage valid/stall pipeline with
// a per-frame write counter that pulses frame_done on the last pixel.
module grayscale_feeder
    import edge_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = edge_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = edge_pkg::IMG_HEIGHT,
    parameter int unsigned CNT_WIDTH  = 19
) (
    input  logic                clock,
    input  logic                reset,
    output logic                in_rd_en,
    input  logic                in_empty,
    input  logic [3*CHAN_W-1:0] in_dout,
    output logic                out_wr_en,
    input  logic                out_full,
    output logic [PIX_W-1:0]    out_din,
    output logic                frame_done
);

    localparam int unsigned FRAME_LEN = IMG_WIDTH * IMG_HEIGHT;

    logic                 s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0]     s1_sum_q, s1_sum_d;
    logic                 s2_valid_q, s2_valid_d;
    pix_t                 s2_gray_q, s2_gray_d;
    logic [CNT_WIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
    logic                 s1_adv, s2_adv;
    pix_t                 gray_c;

    div3_u10 u_div3 (
        .dividend (s1_sum_q),
        .quotient (gray_c)
    );

    // Advance/handshake logic and next-state for both stages and the counter.
    always_comb begin
        s2_adv     = !s2_valid_q || !out_full;
        s1_adv     = !s1_valid_q || s2_adv;
        in_rd_en   = !reset && !in_empty && s1_adv;
        out_wr_en  = s2_valid_q && !out_full;
        frame_done = out_wr_en && (pixel_cnt_q == CNT_WIDTH'(FRAME_LEN - 1));

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s2_valid_d  = s2_valid_q;
        s2_gray_d   = s2_gray_q;
        pixel_cnt_d = pixel_cnt_q;

        if (in_rd_en) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = rgb_sum(rgb_t'(in_dout));
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Gray data only reloads on a real pixel so out_din stays put across bubbles.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_gray_d = gray_c;
            end
        end

        if (frame_done) begin
            pixel_cnt_d = '0;
        end else if (out_wr_en) begin
            pixel_cnt_d = pixel_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_gray_q   <= '0;
            pixel_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_gray_q   <= s2_gray_d;
            pixel_cnt_q <= pixel_cnt_d;
        end
    end

    assign out_din = s2_gray_q;

endmodule

// File: tb/tb_grayscale_feeder.sv
// Randomized bench for grayscale_feeder: a queue-based reference model of
// pops and pushes, directed boundary cases, and a div3_u10 sweep.
module tb_grayscale_feeder;

    localparam int unsigned TB_W  = 8;
    localparam int unsigned TB_H  = 5;
    localparam int unsigned FRAME = TB_W * TB_H;
    localparam int unsigned CW    = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;
    logic [9:0]  div_in;
    logic [7:0]  div_out;

    always #5 clock = ~clock;

    grayscale_feeder #(
        .IMG_WIDTH  (TB_W),
        .IMG_HEIGHT (TB_H),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    div3_u10 u_div (
        .dividend (div_in),
        .quotient (div_out)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int wr_log[$];
    int fd_idx[$];
    int pops, writes, stall_rd, cyc;
    int last_pop_cyc, last_wr_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int gray_of(input logic [23:0] p);
        return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    endfunction

    always @(posedge clock) cyc++;

    // Reference model: every pop enqueues its luminance, every push must match the head.
    always @(negedge clock) begin
        if (!reset) begin
            if (in_rd_en) begin
                check("rd_while_empty", 32'(in_empty), 32'd0);
                exp_q.push_back(gray_of(in_dout));
                pops++;
                last_pop_cyc = cyc;
            end
            if (!in_empty && !in_rd_en) stall_rd++;
            if (out_wr_en) begin
                writes++;
                last_wr_cyc = cyc;
                check("write_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("out_din", 32'(out_din), 32'(exp_q.pop_front()));
                wr_log.push_back(int'(out_din));
                check("frame_done", 32'(frame_done), 32'((writes % FRAME) == 0));
                if (frame_done) fd_idx.push_back(writes);
            end else begin
                check("frame_done_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    task automatic drive(input logic e, input logic f, input logic [23:0] d);
        @(posedge clock);
        #2;
        in_empty = e;
        out_full = f;
        in_dout  = d;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 24'h0);
    endtask

    // Asserts reset off-edge; outputs must clear before the next clock edge.
    task automatic do_reset();
        @(posedge clock);
        #2;
        reset    = 1'b1;
        out_full = 1'b0;
        #1;
        check("rst_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_rd_en", 32'(in_rd_en), 32'd0);
        check("rst_din", 32'(out_din), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        wr_log.delete();
        fd_idx.delete();
        pops   = 0;
        writes = 0;
        repeat (2) @(posedge clock);
        #2;
        in_empty = 1'b1;
        reset    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base, popped, st0, fd0, fd1;
        int ext[4];
        logic [23:0] p;
        ext = '{255, 0, 0, 1};
        pops = 0; writes = 0; stall_rd = 0; cyc = 0;
        reset    = 1'b1;
        in_empty = 1'b0;
        out_full = 1'b0;
        in_dout  = 24'hABCDEF;
        div_in   = '0;

        do_reset();

        // Single pixel: one write of 0x60, two cycles after the pop.
        drive(1'b0, 1'b0, 24'h306090);
        drain(5);
        check("t1_writes", 32'(writes), 32'd1);
        check("t1_value", 32'(wr_log[0]), 32'h60);
        check("t1_latency", 32'(last_wr_cyc - last_pop_cyc), 32'd2);

        // Extremes back to back.
        base = writes;
        drive(1'b0, 1'b0, 24'hFFFFFF);
        drive(1'b0, 1'b0, 24'h000000);
        drive(1'b0, 1'b0, 24'h010100);
        drive(1'b0, 1'b0, 24'h020200);
        drain(5);
        check("t2_writes", 32'(writes - base), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_value", 32'(wr_log[base + i]), 32'(ext[i]));

        for (int s = 0; s <= 765; s++) begin
            div_in = 10'(s);
            #1;
            check("div3", 32'(div_out), 32'(s / 3));
        end

        // Eight pixels with out_full held for cycles 3..7.
        base = writes; st0 = stall_rd; popped = 0;
        for (int c = 0; c < 100 && popped < 8; c++) begin
            drive(1'b0, (c >= 3 && c <= 7), 24'($urandom));
            #1;
            if (in_rd_en) popped++;
        end
        drain(6);
        check("t3_popped", 32'(popped), 32'd8);
        check("t3_writes", 32'(writes - base), 32'd8);
        check("t3_stalled", 32'(stall_rd > st0), 32'd1);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Random empty/full over 1000 pixels.
        base = writes; popped = 0; st0 = pops;
        for (int c = 0; c < 20000 && popped < 1000; c++) begin
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30, 24'($urandom));
            #1;
            if (in_rd_en) popped++;
        end
        drain(8);
        check("t4_popped", 32'(popped), 32'd1000);
        check("t4_balance", 32'(writes - base), 32'(pops - st0));
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages holding data.
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, 24'($urandom) | 24'h808080);
        do_reset();
        p = 24'h3C7A11;
        drive(1'b0, 1'b0, p);
        drain(4);
        check("t6_writes", 32'(writes), 32'd1);
        check("t6_first", 32'(wr_log[0]), 32'(gray_of(p)));

        // Two frames back to back with light random stalls.
        popped = 1;
        for (int c = 0; c < 5000 && popped < 2 * FRAME; c++) begin
            drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20, 24'($urandom));
            #1;
            if (in_rd_en) popped++;
        end
        drain(6);
        fd0 = (fd_idx.size() > 0) ? fd_idx[0] : -1;
        fd1 = (fd_idx.size() > 1) ? fd_idx[1] : -1;
        check("t5_writes", 32'(writes), 32'(2 * FRAME));
        check("t5_pulses", 32'(fd_idx.size()), 32'd2);
        check("t5_first", 32'(fd0), 32'(FRAME));
        check("t5_second", 32'(fd1), 32'(2 * FRAME));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
